// File: rtl/wm8731_pkg.sv
// Shared types and constants for the WM8731 control-port target.
package wm8731_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        BYTE_HI,
        ACK_HI,
        BYTE_LO,
        ACK_LO,
        IGNORE
    } state_t;

    localparam logic [6:0] WM_DEV_ADDR  = 7'h1A;
    localparam logic [6:0] WM_RESET_REG = 7'h0F;
    localparam int         WM_NREGS     = 16;
    localparam int         WM_DATA_W    = 9;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into clk and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Synchroniser chains plus one delayed copy for edge detection; idle bus is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;

endmodule

// File: rtl/wm8731_i2c_target.sv
// Write-only I2C target modelling the WM8731 control port: 3-byte frames into a 16x9 regfile.
module wm8731_i2c_target
    import wm8731_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = WM_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic       reg_wr,
    output logic [6:0] reg_addr,
    output logic [8:0] reg_data,
    output logic       busy,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data
);

    state_t                 state;
    state_t                 state_n;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;
    logic                   sda_s;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic [7:0]             hi_byte;
    logic                   sda_oe;
    logic                   last_bit;
    logic                   sampling;
    logic                   in_ack;
    logic                   ack_end;
    logic                   commit;
    logic [7:0]             byte_n;
    logic [6:0]             frame_addr;
    logic [8:0]             frame_data;
    logic [WM_DATA_W-1:0]   regfile [WM_NREGS];

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl       (i2c_sclk),
        .sda       (i2c_sdat),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    // Open-drain: only ever pull low, released while reset is asserted.
    assign i2c_sdat   = sda_oe ? 1'b0 : 1'bz;
    assign busy       = (state != IDLE);
    assign rd_data    = regfile[rd_addr];
    assign frame_addr = hi_byte[7:1];
    assign frame_data = {hi_byte[0], shreg};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state decode; START/STOP pre-empt any bit or ACK handling.
    always_comb begin
        state_n  = state;
        commit   = 1'b0;
        byte_n   = {shreg[6:0], sda_s};
        sampling = (state == ADDR) || (state == BYTE_HI) || (state == BYTE_LO);
        in_ack   = (state == ACK_ADDR) || (state == ACK_HI) || (state == ACK_LO);
        last_bit = sampling && scl_rise && (bit_cnt == 3'd7);
        ack_end  = in_ack && scl_fall && sda_oe;
        if (stop_det) begin
            state_n = IDLE;
        end else if (start_det) begin
            state_n = ADDR;
        end else begin
            case (state)
                ADDR:     if (last_bit) state_n = (byte_n[7:1] == DEV_ADDR && !byte_n[0]) ? ACK_ADDR : IGNORE;
                ACK_ADDR: if (ack_end) state_n = BYTE_HI;
                BYTE_HI:  if (last_bit) state_n = ACK_HI;
                ACK_HI:   if (ack_end) state_n = BYTE_LO;
                BYTE_LO:  if (last_bit) state_n = ACK_LO;
                ACK_LO:   if (ack_end) begin
                              state_n = IGNORE;
                              commit  = 1'b1;
                          end
                default:  ;
            endcase
        end
    end

    // Bit shifter, ACK driver and commit outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            hi_byte  <= '0;
            sda_oe   <= 1'b0;
            reg_wr   <= 1'b0;
            reg_addr <= '0;
            reg_data <= '0;
        end else begin
            reg_wr <= commit;
            if (stop_det || start_det) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else begin
                if (sampling && scl_rise) begin
                    shreg   <= byte_n;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (state == BYTE_HI && last_bit)
                    hi_byte <= byte_n;
                // First fall in an ACK state starts the slot, the second one ends it.
                if (in_ack && scl_fall)
                    sda_oe <= ~sda_oe;
            end
            if (commit) begin
                reg_addr <= frame_addr;
                reg_data <= frame_data;
            end
        end
    end

    // Register file: the reset register clears everything, upper addresses are not stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WM_NREGS; i++) regfile[i] <= '0;
        end else if (commit) begin
            if (frame_addr == WM_RESET_REG) begin
                for (int i = 0; i < WM_NREGS; i++) regfile[i] <= '0;
            end else if (frame_addr < WM_RESET_REG) begin
                regfile[frame_addr[3:0]] <= frame_data;
            end
        end
    end

endmodule

// File: tb/tb_wm8731_i2c_target.sv
// Directed bench for wm8731_i2c_target: bit-banged I2C master on a pulled-up SDA line.
`timescale 1ns/1ps
module tb_wm8731_i2c_target;

    localparam time Q = 200ns;   // SCL quarter period (10 clk), SCL = clk/40

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       reg_wr;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic       busy;
    logic [3:0] rd_addr = 4'd0;
    logic [8:0] rd_data;
    wire        i2c_sdat;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int low_cnt = 0;

    pullup (i2c_sdat);
    assign i2c_sdat = m_sda ? 1'bz : 1'b0;

    wm8731_i2c_target dut (
        .clk      (clk),
        .reset    (reset),
        .i2c_sclk (scl),
        .i2c_sdat (i2c_sdat),
        .reg_wr   (reg_wr),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .busy     (busy),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #10 clk = ~clk;

    // Count write strobes and cycles where the target pulls SDA low.
    always @(posedge clk) begin
        if (reg_wr) wr_cnt++;
        if (m_sda && i2c_sdat === 1'b0) low_cnt++;
    end

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b0; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b1; #Q;
        #Q;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda = b[i]; #Q;
            scl = 1'b1;   #Q; #Q;
            scl = 1'b0;   #Q;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        ack = (i2c_sdat === 1'b0);
        #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic write_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                               output logic [2:0] acks);
        logic k;
        i2c_start();
        send_byte(a, k); acks[2] = k;
        send_byte(h, k); acks[1] = k;
        send_byte(l, k); acks[0] = k;
        i2c_stop();
    endtask

    task automatic test_reset();
        #95;
        total++; if (reg_wr !== 1'b0)      begin bad++; $display("FAIL rst_wr got=%b want=0", reg_wr); end
        total++; if (reg_addr !== 7'h00)   begin bad++; $display("FAIL rst_addr got=%h want=00", reg_addr); end
        total++; if (reg_data !== 9'h000)  begin bad++; $display("FAIL rst_data got=%h want=000", reg_data); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (i2c_sdat !== 1'b1)    begin bad++; $display("FAIL rst_sda got=%b want=1", i2c_sdat); end
        rd_addr = 4'd5; #1;
        total++; if (rd_data !== 9'h000)   begin bad++; $display("FAIL rst_rd got=%h want=000", rd_data); end
        @(negedge clk); reset = 1'b0;
        #Q;
    endtask

    task automatic test_valid_write();
        logic [2:0] acks;
        int w0 = wr_cnt;
        write_frame(8'h34, 8'h0C, 8'hA7, acks);
        total++; if (acks !== 3'b111)      begin bad++; $display("FAIL vw_acks got=%b want=111", acks); end
        total++; if (wr_cnt - w0 != 1)     begin bad++; $display("FAIL vw_wrcnt got=%0d want=1", wr_cnt - w0); end
        total++; if (reg_addr !== 7'h06)   begin bad++; $display("FAIL vw_addr got=%h want=06", reg_addr); end
        total++; if (reg_data !== 9'h0A7)  begin bad++; $display("FAIL vw_data got=%h want=0a7", reg_data); end
        rd_addr = 4'd6; #1;
        total++; if (rd_data !== 9'h0A7)   begin bad++; $display("FAIL vw_rd got=%h want=0a7", rd_data); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL vw_busy got=%b want=0", busy); end
    endtask

    task automatic test_wrong_device();
        logic [2:0] acks;
        int w0 = wr_cnt;
        int l0 = low_cnt;
        write_frame(8'h36, 8'h0C, 8'hA7, acks);
        total++; if (acks !== 3'b000)      begin bad++; $display("FAIL wd_acks got=%b want=000", acks); end
        total++; if (low_cnt != l0)        begin bad++; $display("FAIL wd_sda_low got=%0d want=0", low_cnt - l0); end
        total++; if (wr_cnt != w0)         begin bad++; $display("FAIL wd_wrcnt got=%0d want=0", wr_cnt - w0); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL wd_busy got=%b want=0", busy); end
    endtask

    task automatic test_read_request();
        logic [2:0] acks;
        int w0 = wr_cnt;
        write_frame(8'h35, 8'h0C, 8'hA7, acks);
        total++; if (acks !== 3'b000)      begin bad++; $display("FAIL rr_acks got=%b want=000", acks); end
        total++; if (wr_cnt != w0)         begin bad++; $display("FAIL rr_wrcnt got=%0d want=0", wr_cnt - w0); end
    endtask

    task automatic test_truncated();
        logic k1, k2;
        int w0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, k1);
        send_byte(8'h0D, k2);
        i2c_stop();
        total++; if ({k1, k2} !== 2'b11)   begin bad++; $display("FAIL tr_acks got=%b want=11", {k1, k2}); end
        total++; if (wr_cnt != w0)         begin bad++; $display("FAIL tr_wrcnt got=%0d want=0", wr_cnt - w0); end
        rd_addr = 4'd6; #1;
        total++; if (rd_data !== 9'h0A7)   begin bad++; $display("FAIL tr_rd6 got=%h want=0a7", rd_data); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL tr_busy got=%b want=0", busy); end
    endtask

    task automatic test_repeated_start();
        logic k;
        logic [2:0] acks;
        int w0 = wr_cnt;
        i2c_start();
        send_byte(8'h34, k);
        send_byte(8'h0C, k);
        send_bits(8'hFF, 3);
        write_frame(8'h34, 8'h12, 8'h55, acks);
        total++; if (acks !== 3'b111)      begin bad++; $display("FAIL rs_acks got=%b want=111", acks); end
        total++; if (wr_cnt - w0 != 1)     begin bad++; $display("FAIL rs_wrcnt got=%0d want=1", wr_cnt - w0); end
        rd_addr = 4'd9; #1;
        total++; if (rd_data !== 9'h055)   begin bad++; $display("FAIL rs_rd9 got=%h want=055", rd_data); end
        rd_addr = 4'd6; #1;
        total++; if (rd_data !== 9'h0A7)   begin bad++; $display("FAIL rs_rd6 got=%h want=0a7", rd_data); end
    endtask

    task automatic test_reset_register();
        logic [2:0] acks;
        write_frame(8'h34, 8'h04, 8'h11, acks);
        write_frame(8'h34, 8'h0D, 8'h23, acks);
        rd_addr = 4'd6; #1;
        total++; if (rd_data !== 9'h123)   begin bad++; $display("FAIL rr_pre6 got=%h want=123", rd_data); end
        write_frame(8'h34, 8'h1E, 8'h00, acks);
        total++; if (reg_addr !== 7'h0F)   begin bad++; $display("FAIL rreg_addr got=%h want=0f", reg_addr); end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i); #1;
            total++; if (rd_data !== 9'h000) begin bad++; $display("FAIL rreg_rd%0d got=%h want=000", i, rd_data); end
        end
    endtask

    task automatic test_upper_addr();
        logic [2:0] acks;
        int w0 = wr_cnt;
        write_frame(8'h34, 8'h21, 8'h3C, acks);
        total++; if (wr_cnt - w0 != 1)     begin bad++; $display("FAIL up_wrcnt got=%0d want=1", wr_cnt - w0); end
        total++; if (reg_addr !== 7'h10)   begin bad++; $display("FAIL up_addr got=%h want=10", reg_addr); end
        total++; if (reg_data !== 9'h13C)  begin bad++; $display("FAIL up_data got=%h want=13c", reg_data); end
        rd_addr = 4'd0; #1;
        total++; if (rd_data !== 9'h000)   begin bad++; $display("FAIL up_rd0 got=%h want=000", rd_data); end
    endtask

    task automatic test_reset_mid_ack();
        logic [2:0] acks;
        logic k;
        write_frame(8'h34, 8'h06, 8'h5A, acks);
        rd_addr = 4'd3; #1;
        total++; if (rd_data !== 9'h05A)   begin bad++; $display("FAIL rma_pre got=%h want=05a", rd_data); end
        i2c_start();
        send_byte(8'h34, k);
        send_bits(8'h0C, 8);
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        total++; if (i2c_sdat !== 1'b0)    begin bad++; $display("FAIL rma_ack got=%b want=0", i2c_sdat); end
        reset = 1'b1; #1;
        total++; if (i2c_sdat !== 1'b1)    begin bad++; $display("FAIL rma_sda got=%b want=1", i2c_sdat); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rma_busy got=%b want=0", busy); end
        total++; if (reg_addr !== 7'h00)   begin bad++; $display("FAIL rma_addr got=%h want=00", reg_addr); end
        total++; if (rd_data !== 9'h000)   begin bad++; $display("FAIL rma_rd3 got=%h want=000", rd_data); end
        #100;
        @(negedge clk); reset = 1'b0;
        scl = 1'b0; #Q;
        i2c_stop();
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rma_idle got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_valid_write();
        test_wrong_device();
        test_read_request();
        test_truncated();
        test_repeated_start();
        test_reset_register();
        test_upper_addr();
        test_reset_mid_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
